req_encoder16to4: RTL
=====================

// Module: req_encoder16to4
// PURPOSE
//  Reverse of the 4-to-16 one-hot decoder: collects up to 16 request lines into a sticky
//  pending set and emits one 4-bit binary index per grant via VALID/READY handshake.
//  Round-robin among pending bits; one grant per cycle max. Feeds the assembly-stage
//  control path, which consumes indices serially.
// PARAMETERS
//  WIDTH  16  number of request lines; fixed power of two
//  IDXW   4   index width = log2(WIDTH)
//  RR     1   1 = round-robin from pointer; 0 = fixed priority, lowest index first
// PORTS
//  CLK    in   1      single clock, rising edge
//  RST    in   1      synchronous, active-high reset
//  EN     in   1      capture enable for REQ; pending set still drains when low
//  REQ    in   WIDTH  request pulses/levels; bit i sampled each cycle EN=1
//  READY  in   1      consumer accepts IDX this cycle when VALID=1
//  VALID  out  1      IDX holds a pending index
//  IDX    out  IDXW   granted index, binary
//  PEND   out  WIDTH  registered pending set
//  DROP   out  1      1-cycle pulse: REQ bit arrived (EN=1) while already pending
// BEHAVIOUR
//  - Reset (RST=1 at edge, overrides everything): PEND=0, PTR=0, state=IDLE, VALID=0,
//    IDX=0, DROP=0. Reset mid-offer discards offer and all pending bits.
//  - Capture: PEND_next = (PEND & ~clr_mask) | (EN ? REQ : 0); set wins over clear.
//    clr_mask = one-hot(IDX) when VALID&READY, else 0.
//  - DROP = EN & |(REQ & PEND & ~clr_mask), registered (pulse one cycle after).
//  - Pick (sub-module): search masked set M from PTR upward, wrap 15->0; RR=0 uses PTR=0.
//  - FSM, two states:
//    IDLE : VALID=0. If PEND!=0 -> OFFER; IDX<=pick(PEND). Else stay.
//    OFFER: VALID=1; IDX stable while READY=0 (no reselection, even if new bits arrive).
//           On VALID&READY: PTR<=IDX+1 (mod 16, wraps 15->0);
//           M = PEND & ~one-hot(IDX) (REQ arriving this cycle not eligible until next pick);
//           if M!=0 stay OFFER, IDX<=pick(M) starting at IDX+1; else -> IDLE, VALID<=0.
//  - Latency: REQ at cycle 0 (EN=1, idle) -> PEND set at edge 1 -> VALID=1 in cycle 2.
//  - Throughput: back-to-back grants, 1 per cycle while READY=1 and set nonempty.
//  - Repeated pulses on a pending bit coalesce to one grant (+DROP each extra pulse).
//  - Bit re-requested in its own handshake cycle: stays pending, granted again later.
//  - EN=0: REQ ignored, DROP=0; offer and drain continue unchanged.
//  - IDX holds last value when VALID=0 (not cleared except by reset).
// STRUCTURE
//  - Shared package/header enc_pkg: WIDTH, IDXW defaults; state encoding ST_IDLE=0,
//    ST_OFFER=1; onehot16 function used by both this block and decoder tests.
//  - Sub-module rr_pick16: combinational; in M[15:0], PTR[3:0] -> ANY, SEL[3:0];
//    rotate right by PTR, lowest-set-bit find, add PTR mod 16.
//  - Top: PEND reg, PTR reg, FSM, IDX/VALID/DROP regs.
// TESTING
//  1 Reset: RST=1 with REQ=16'hFFFF, EN=1 -> VALID=0, IDX=0, PEND=0, DROP=0 next cycle.
//  2 Single: REQ=16'h0020 one cycle, READY=1 -> VALID=1 cycle 2, IDX=5, then VALID=0.
//  3 RR wrap: PTR=14 (after grant of 13), PEND=16'h8003, READY=1 -> IDX 15,0,1 in
//    consecutive cycles, then IDLE; RR=0 same set -> 0,1,15.
//  4 Backpressure: PEND=16'h0110, READY=0 10 cycles, REQ=16'h0001 arrives -> IDX=4 held;
//    READY=1 -> next IDX=8, then 0.
//  5 Coalesce/DROP: REQ bit3 pulsed 3 times before READY -> DROP pulses twice, one grant IDX=3.
//  6 Set-vs-clear: handshake on IDX=7 same cycle REQ=16'h0080 -> PEND[7]=1, granted again later;
//    EN=0 with REQ=16'hFFFF -> PEND unchanged, DROP=0; RST mid-OFFER -> VALID=0 next cycle.

Source files
------------

// File: rtl/req_encoder16to4_pkg.sv
// Shared definitions for the 16-to-4 request encoder: sizes, FSM state
// encoding and the one-hot helper that the decoder tests also use.
package req_encoder16to4_pkg;

   localparam int WIDTH = 16;
   localparam int IDXW  = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OFFER = 1'b1
   } state_t;

   // One-hot vector with only bit 'idx' set.
   function automatic logic [WIDTH-1:0] onehot16(input logic [IDXW-1:0] idx);
      logic [WIDTH-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/req_encoder16to4_if.sv
// Request/grant bundle of the encoder. The slave side is the encoder,
// the master side drives requests and consumes granted indices.
interface req_encoder16to4_if;
   import req_encoder16to4_pkg::*;

   logic             en;
   logic [WIDTH-1:0] req;
   logic             ready;
   logic             valid;
   logic [IDXW-1:0]  idx;
   logic [WIDTH-1:0] pend;
   logic             drop;

   modport master (
      output en, req, ready,
      input  valid, idx, pend, drop
   );

   modport slave (
      input  en, req, ready,
      output valid, idx, pend, drop
   );

endinterface

// File: rtl/req_encoder16to4_rr_pick16.sv
// Combinational round-robin picker: finds the first set bit of i_m at or
// above i_ptr, wrapping from bit 15 back to bit 0.
module rr_pick16
   import req_encoder16to4_pkg::*;
(
   input  logic [WIDTH-1:0] i_m,
   input  logic [IDXW-1:0]  i_ptr,
   output logic             o_any,
   output logic [IDXW-1:0]  o_sel
);

   logic [2*WIDTH-1:0] w_dbl;
   logic [WIDTH-1:0]   w_rot;
   logic [IDXW-1:0]    w_low;

   // Rotating right by the pointer turns "first at/after ptr" into "lowest set".
   assign w_dbl = {i_m, i_m} >> i_ptr;
   assign w_rot = w_dbl[WIDTH-1:0];

   // Lowest-set-bit search; scanning downward lets the lowest hit win.
   always_comb begin
      w_low = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_low = i[IDXW-1:0];
         end
      end
   end

   // Undo the rotation; the 4-bit add wraps modulo 16 naturally.
   assign o_sel = w_low + i_ptr;
   assign o_any = |i_m;

endmodule

// File: rtl/req_encoder16to4.sv
// 16-to-4 request encoder: sticky pending set, one granted index per
// VALID/READY handshake, round-robin (RR=1) or lowest-first (RR=0).
module req_encoder16to4
   import req_encoder16to4_pkg::*;
#(
   parameter int RR = 1
)
(
   input  logic               i_clk,
   input  logic               i_rst,
   req_encoder16to4_if.slave  bus
);

   state_t           r_state;
   logic [WIDTH-1:0] r_pend;
   logic [IDXW-1:0]  r_ptr;
   logic [IDXW-1:0]  r_idx;
   logic             r_valid;
   logic             r_drop;

   logic             w_hs;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_cap;
   logic [WIDTH-1:0] w_pend_next;
   logic             w_drop_next;
   logic [WIDTH-1:0] w_pick_m;
   logic [IDXW-1:0]  w_pick_start;
   logic [IDXW-1:0]  w_pick_ptr;
   logic             w_any;
   logic [IDXW-1:0]  w_sel;

   // A completed handshake retires the offered bit; new requests win over it.
   assign w_hs        = r_valid & bus.ready;
   assign w_clr       = w_hs ? onehot16(r_idx) : '0;
   assign w_cap       = bus.en ? bus.req : '0;
   assign w_pend_next = (r_pend & ~w_clr) | w_cap;
   assign w_drop_next = bus.en & (|(bus.req & r_pend & ~w_clr));

   // While offering, the next pick excludes the bit being granted and only
   // sees the registered set, so same-cycle requests wait for a later pick.
   assign w_pick_m     = (r_state == ST_OFFER) ? (r_pend & ~onehot16(r_idx)) : r_pend;
   assign w_pick_start = (r_state == ST_OFFER) ? (r_idx + IDXW'(1)) : r_ptr;
   assign w_pick_ptr   = (RR != 0) ? w_pick_start : '0;

   rr_pick16 u_pick (
      .i_m   (w_pick_m),
      .i_ptr (w_pick_ptr),
      .o_any (w_any),
      .o_sel (w_sel)
   );

   // Pending set, drop pulse and the IDLE/OFFER grant state machine.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_pend  <= '0;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_pend <= w_pend_next;
         r_drop <= w_drop_next;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_state <= ST_OFFER;
                  r_valid <= 1'b1;
                  r_idx   <= w_sel;
               end
            end
            ST_OFFER: begin
               // IDX is frozen until the consumer takes it.
               if (bus.ready) begin
                  r_ptr <= r_idx + IDXW'(1);
                  if (w_any) begin
                     r_idx <= w_sel;
                  end else begin
                     r_state <= ST_IDLE;
                     r_valid <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.valid = r_valid;
   assign bus.idx   = r_idx;
   assign bus.pend  = r_pend;
   assign bus.drop  = r_drop;

endmodule
